// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data/memory bus bundle shared by the arbiter and its neighbours
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // instruction fetch side
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_flush;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;
    // data access side
    logic            dm_req;
    logic            dm_we;
    logic [DW/8-1:0] dm_be;
    logic [AW-1:0]   dm_addr;
    logic [DW-1:0]   dm_wdata;
    logic            dm_gnt;
    logic            dm_rvalid;
    logic [DW-1:0]   dm_rdata;
    // external memory side
    logic            bus_req;
    logic            bus_we;
    logic [DW/8-1:0] bus_be;
    logic [AW-1:0]   bus_addr;
    logic [DW-1:0]   bus_wdata;
    logic            bus_gnt;
    logic            bus_rvalid;
    logic [DW-1:0]   bus_rdata;

    // arbiter view
    modport slave (
        input  if_req, if_addr, if_flush,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output dm_gnt, dm_rvalid, dm_rdata,
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata
    );

    // requester / memory view
    modport master (
        output if_req, if_addr, if_flush,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output bus_gnt, bus_rvalid, bus_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  dm_gnt, dm_rvalid, dm_rdata,
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding IF/DM arbiter onto one unified memory bus
module mem_port_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave mif
);
    localparam int BW = DW / 8;
    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    state_t          state_q, state_d;
    owner_t          owner_q, owner_d;
    logic            killed_q, killed_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [BW-1:0]   be_q, be_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            dm_win, if_win;

    // Arbitration, bus drive and response routing; all outputs held at 0 while reset is asserted
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        killed_d      = killed_q;
        streak_d      = streak_q;
        addr_d        = addr_q;
        we_d          = we_q;
        be_d          = be_q;
        wdata_d       = wdata_q;
        dm_win        = 1'b0;
        if_win        = 1'b0;
        mif.if_gnt    = 1'b0;
        mif.if_rvalid = 1'b0;
        mif.if_rdata  = '0;
        mif.dm_gnt    = 1'b0;
        mif.dm_rvalid = 1'b0;
        mif.dm_rdata  = '0;
        mif.bus_req   = 1'b0;
        mif.bus_we    = 1'b0;
        mif.bus_be    = '0;
        mif.bus_addr  = '0;
        mif.bus_wdata = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    killed_d = 1'b0;
                    // DM wins unless IF has already been passed over MAX_DM_STREAK times in a row
                    dm_win = mif.dm_req && !(mif.if_req && (streak_q == STREAK_MAX));
                    if_win = !dm_win && mif.if_req && !mif.if_flush;
                    if (dm_win) begin
                        mif.dm_gnt = 1'b1;
                        owner_d    = OWN_DM;
                        addr_d     = mif.dm_addr;
                        we_d       = mif.dm_we;
                        be_d       = mif.dm_be;
                        wdata_d    = mif.dm_wdata;
                        if (mif.if_req)
                            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
                        else
                            streak_d = '0;
                        state_d = REQ;
                    end else if (if_win) begin
                        mif.if_gnt = 1'b1;
                        owner_d    = OWN_IF;
                        addr_d     = mif.if_addr;
                        we_d       = 1'b0;
                        be_d       = '1;
                        wdata_d    = '0;
                        streak_d   = '0;
                        state_d    = REQ;
                    end
                end
                REQ: begin
                    // request stays up even for a killed fetch; the memory must see it through
                    mif.bus_req   = 1'b1;
                    mif.bus_we    = we_q;
                    mif.bus_be    = be_q;
                    mif.bus_addr  = addr_q;
                    mif.bus_wdata = wdata_q;
                    if (owner_q == OWN_IF && mif.if_flush)
                        killed_d = 1'b1;
                    if (mif.bus_gnt)
                        state_d = WAIT;
                end
                WAIT: begin
                    if (owner_q == OWN_IF && mif.if_flush)
                        killed_d = 1'b1;
                    if (mif.bus_rvalid) begin
                        state_d  = IDLE;
                        killed_d = 1'b0;
                        if (owner_q == OWN_DM) begin
                            mif.dm_rvalid = 1'b1;
                            mif.dm_rdata  = mif.bus_rdata;
                        end else if (!(killed_q || mif.if_flush)) begin
                            // a flush arriving with the response kills it as well
                            mif.if_rvalid = 1'b1;
                            mif.if_rdata  = mif.bus_rdata;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and latched transaction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            killed_q <= 1'b0;
            streak_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            killed_q <= killed_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(32), .DW(32)) mif ();

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_DM_STREAK(4)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic clear_inputs();
        mif.if_req     = 1'b0;
        mif.if_addr    = '0;
        mif.if_flush   = 1'b0;
        mif.dm_req     = 1'b0;
        mif.dm_we      = 1'b0;
        mif.dm_be      = '0;
        mif.dm_addr    = '0;
        mif.dm_wdata   = '0;
        mif.bus_gnt    = 1'b0;
        mif.bus_rvalid = 1'b0;
        mif.bus_rdata  = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnts"},    32'({mif.if_gnt, mif.dm_gnt}), 0);
        check({tag, "_rvalids"}, 32'({mif.if_rvalid, mif.dm_rvalid}), 0);
        check({tag, "_if_rdata"}, mif.if_rdata, 0);
        check({tag, "_dm_rdata"}, mif.dm_rdata, 0);
        check({tag, "_bus_ctl"}, 32'({mif.bus_req, mif.bus_we, mif.bus_be}), 0);
        check({tag, "_bus_addr"}, mif.bus_addr, 0);
        check({tag, "_bus_wdata"}, mif.bus_wdata, 0);
    endtask

    // Entered one cycle after a grant (REQ state); plays the memory and checks the bus and response
    task automatic serve(input string tag, input logic dm, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata, input int gnt_wait,
                         input int rv_wait, input logic [31:0] rdata, input logic exp_rv,
                         input int flush_at);
        for (int i = 0; i <= gnt_wait; i++) begin
            mif.bus_gnt = (i == gnt_wait);
            settle();
            check({tag, "_bus_req"},   32'(mif.bus_req), 1);
            check({tag, "_bus_we"},    32'(mif.bus_we), 32'(we));
            check({tag, "_bus_be"},    32'(mif.bus_be), 32'(be));
            check({tag, "_bus_addr"},  mif.bus_addr, addr);
            check({tag, "_bus_wdata"}, mif.bus_wdata, wdata);
            check({tag, "_req_gnts"},  32'({mif.if_gnt, mif.dm_gnt}), 0);
            tick();
        end
        mif.bus_gnt = 1'b0;
        for (int j = 0; j <= rv_wait; j++) begin
            mif.bus_rvalid = (j == rv_wait);
            mif.bus_rdata  = (j == rv_wait) ? rdata : 32'hBAD0_BAD0;
            mif.if_flush   = (j == flush_at);
            settle();
            check({tag, "_wait_bus_req"}, 32'(mif.bus_req), 0);
            if (j == rv_wait) begin
                check({tag, "_if_rvalid"}, 32'(mif.if_rvalid), 32'(!dm && exp_rv));
                check({tag, "_if_rdata"},  mif.if_rdata, (!dm && exp_rv) ? rdata : 32'h0);
                check({tag, "_dm_rvalid"}, 32'(mif.dm_rvalid), 32'(dm && exp_rv));
                check({tag, "_dm_rdata"},  mif.dm_rdata, (dm && exp_rv) ? rdata : 32'h0);
            end else begin
                check({tag, "_early_rvalids"}, 32'({mif.if_rvalid, mif.dm_rvalid}), 0);
            end
            tick();
        end
        mif.bus_rvalid = 1'b0;
        mif.bus_rdata  = '0;
        mif.if_flush   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        settle();
        check_zero("rst");
        tick();
        reset = 1'b0;

        // single fetch at minimum latency
        mif.if_req  = 1'b1;
        mif.if_addr = 32'h100;
        settle();
        check("fetch_if_gnt", 32'(mif.if_gnt), 1);
        check("fetch_dm_gnt", 32'(mif.dm_gnt), 0);
        check("fetch_bus_req0", 32'(mif.bus_req), 0);
        tick();
        mif.if_req = 1'b0;
        serve("fetch", 1'b0, 1'b0, 4'hf, 32'h100, 32'h0, 0, 0, 32'h0050_0093, 1'b1, -1);
        settle();
        check("fetch_after_rvalid", 32'(mif.if_rvalid), 0);
        tick();

        // simultaneous requests: DM first, IF at next IDLE
        mif.if_req   = 1'b1;
        mif.if_addr  = 32'h104;
        mif.dm_req   = 1'b1;
        mif.dm_we    = 1'b0;
        mif.dm_be    = 4'hf;
        mif.dm_addr  = 32'h2000;
        mif.dm_wdata = 32'h0;
        settle();
        check("prio_dm_gnt", 32'(mif.dm_gnt), 1);
        check("prio_if_gnt", 32'(mif.if_gnt), 0);
        tick();
        mif.dm_req = 1'b0;
        serve("prio_dm", 1'b1, 1'b0, 4'hf, 32'h2000, 32'h0, 0, 0, 32'h1122_3344, 1'b1, -1);
        settle();
        check("prio_if_gnt2", 32'(mif.if_gnt), 1);
        check("prio_dm_gnt2", 32'(mif.dm_gnt), 0);
        tick();
        mif.if_req = 1'b0;
        serve("prio_if", 1'b0, 1'b0, 4'hf, 32'h104, 32'h0, 0, 0, 32'h0000_0013, 1'b1, -1);

        // anti-starvation: D D D D I D
        mif.if_req  = 1'b1;
        mif.if_addr = 32'h200;
        mif.dm_req  = 1'b1;
        mif.dm_addr = 32'h3000;
        for (int k = 0; k < 6; k++) begin
            settle();
            check($sformatf("starve%0d_dm_gnt", k), 32'(mif.dm_gnt), 32'(k != 4));
            check($sformatf("starve%0d_if_gnt", k), 32'(mif.if_gnt), 32'(k == 4));
            tick();
            if (k != 4)
                serve($sformatf("starve%0d", k), 1'b1, 1'b0, 4'hf, 32'h3000, 32'h0, 0, 0,
                      32'h1000 + 32'(k), 1'b1, -1);
            else
                serve($sformatf("starve%0d", k), 1'b0, 1'b0, 4'hf, 32'h200, 32'h0, 0, 0,
                      32'h1000 + 32'(k), 1'b1, -1);
        end
        mif.if_req = 1'b0;
        mif.dm_req = 1'b0;

        // flush in WAIT kills the response; bus still completes
        mif.if_req  = 1'b1;
        mif.if_addr = 32'h300;
        settle();
        check("flush_if_gnt", 32'(mif.if_gnt), 1);
        tick();
        mif.if_req = 1'b0;
        serve("flush", 1'b0, 1'b0, 4'hf, 32'h300, 32'h0, 0, 3, 32'hCAFE_F00D, 1'b0, 1);

        // flush in IDLE blocks the IF grant for that cycle only
        mif.if_req   = 1'b1;
        mif.if_addr  = 32'h304;
        mif.if_flush = 1'b1;
        settle();
        check("idle_flush_if_gnt", 32'(mif.if_gnt), 0);
        tick();
        mif.if_flush = 1'b0;
        settle();
        check("post_flush_if_gnt", 32'(mif.if_gnt), 1);
        tick();
        mif.if_req = 1'b0;
        serve("post_flush", 1'b0, 1'b0, 4'hf, 32'h304, 32'h0, 0, 0, 32'h0000_0093, 1'b1, -1);

        // store through a 2-cycle bus_gnt stall; if_flush during it must not matter
        mif.dm_req   = 1'b1;
        mif.dm_we    = 1'b1;
        mif.dm_be    = 4'b0011;
        mif.dm_addr  = 32'h40;
        mif.dm_wdata = 32'hDEAD_BEEF;
        settle();
        check("store_dm_gnt", 32'(mif.dm_gnt), 1);
        tick();
        mif.dm_req   = 1'b0;
        mif.dm_we    = 1'b0;
        mif.dm_be    = 4'hf;
        mif.dm_addr  = 32'h0;
        mif.dm_wdata = 32'h0;
        serve("store", 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 2, 0, 32'h0000_0000, 1'b1, 0);

        // reset asserted for 2 cycles while a fetch waits for its response
        mif.if_req  = 1'b1;
        mif.if_addr = 32'h400;
        settle();
        check("rstw_if_gnt", 32'(mif.if_gnt), 1);
        tick();
        mif.if_req  = 1'b0;
        mif.bus_gnt = 1'b1;
        settle();
        check("rstw_bus_req", 32'(mif.bus_req), 1);
        tick();
        mif.bus_gnt = 1'b0;
        reset = 1'b1;
        settle();
        check_zero("rstw_a");
        tick();
        settle();
        check_zero("rstw_b");
        tick();
        reset = 1'b0;
        settle();
        check_zero("rstw_after");
        tick();
        mif.if_req  = 1'b1;
        mif.if_addr = 32'h500;
        settle();
        check("rstw_idle_if_gnt", 32'(mif.if_gnt), 1);
        tick();
        mif.if_req = 1'b0;
        serve("rstw_fetch", 1'b0, 1'b0, 4'hf, 32'h500, 32'h0, 0, 0, 32'h0000_0013, 1'b1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
